// File: rtl/mem_ctrl_pkg.sv
// Shared types and widths for the mem_ctrl SRAM controller.
// The HIT state exists only when MEM_CTRL_PREFETCH_EN is defined.
package mem_ctrl_pkg;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 4;

`ifdef MEM_CTRL_PREFETCH_EN
    typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_DONE, ST_HIT} state_e;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_DONE} state_e;
`endif
endpackage

// File: rtl/mem_ctrl_if.sv
// Core request bus and external SRAM pins of mem_ctrl, bundled as one interface.
// master = core/SRAM side, slave = the controller.
interface mem_ctrl_if;
    import mem_ctrl_pkg::*;

    logic              core_req;
    logic              core_rw;
    logic [ADDR_W-1:0] core_ad;
    logic [DATA_W-1:0] core_dout;
    logic [DATA_W-1:0] core_din;
    logic              core_rdy;
    logic              mem_ce_n;
    logic              mem_oe_n;
    logic              mem_we_n;
    logic [ADDR_W-1:0] mem_a;
    logic [DATA_W-1:0] mem_dq_o;
    logic [DATA_W-1:0] mem_dq_i;

    modport master (
        output core_req, core_rw, core_ad, core_dout, mem_dq_i,
        input  core_din, core_rdy, mem_ce_n, mem_oe_n, mem_we_n, mem_a, mem_dq_o
    );

    modport slave (
        input  core_req, core_rw, core_ad, core_dout, mem_dq_i,
        output core_din, core_rdy, mem_ce_n, mem_oe_n, mem_we_n, mem_a, mem_dq_o
    );
endinterface

// File: rtl/mem_ctrl_prefetch.sv
// One-byte sequential prefetch buffer (data, address tag, valid, comparator).
// Only built when MEM_CTRL_PREFETCH_EN is defined.
`ifdef MEM_CTRL_PREFETCH_EN
module mem_ctrl_prefetch
    import mem_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] load_addr_i,
    input  logic [DATA_W-1:0] load_data_i,
    input  logic              clr_i,
    input  logic [ADDR_W-1:0] lookup_addr_i,
    output logic              hit_o,
    output logic [DATA_W-1:0] data_o
);
    logic              valid_q;
    logic [ADDR_W-1:0] tag_q;
    logic [DATA_W-1:0] data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            data_q  <= '0;
        end else if (clr_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            tag_q   <= load_addr_i;
            data_q  <= load_data_i;
        end
    end

    assign hit_o  = valid_q && (tag_q == lookup_addr_i);
    assign data_o = data_q;
endmodule
`endif

// File: rtl/mem_ctrl.sv
// mem_ctrl: async SRAM controller, WAIT_STATES extra cycles per access, one-cycle rdy pulse.
// Define MEM_CTRL_PREFETCH_EN to add the sequential one-byte prefetch buffer.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int WAIT_STATES = 1
) (
    input logic       clk,
    input logic       rst_n,
    mem_ctrl_if.slave bus
);
    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              rw_q;
    logic              rdy_q;
    logic              ce_n_q;
    logic              oe_n_q;
    logic              we_n_q;
    logic              open_st;
    logic              accept;
    logic              acc_done;

`ifdef MEM_CTRL_PREFETCH_EN
    logic              pf_act_q;
    logic              pf_pend_q;
    logic [ADDR_W-1:0] pf_addr_q;
    logic              pf_hit;
    logic              hit_go;
    logic              pf_start;
    logic [DATA_W-1:0] pf_data;

    mem_ctrl_prefetch u_prefetch (
        .clk           (clk),
        .rst_n         (rst_n),
        .load_i        (acc_done && pf_act_q),
        .load_addr_i   (addr_q),
        .load_data_i   (bus.mem_dq_i),
        .clr_i         (accept && !bus.core_rw),
        .lookup_addr_i (bus.core_ad),
        .hit_o         (pf_hit),
        .data_o        (pf_data)
    );

    assign open_st  = (state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_HIT);
    assign hit_go   = open_st && bus.core_req && bus.core_rw && pf_hit;
    assign pf_start = (state_q == ST_IDLE) && !bus.core_req && pf_pend_q;
    assign accept   = open_st && bus.core_req && !hit_go;
`else
    assign open_st  = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign accept   = open_st && bus.core_req;
`endif
    assign acc_done = (state_q == ST_ACCESS) && (cnt_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            rw_q    <= 1'b0;
            rdy_q   <= 1'b0;
            ce_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
`ifdef MEM_CTRL_PREFETCH_EN
            pf_act_q  <= 1'b0;
            pf_pend_q <= 1'b0;
            pf_addr_q <= '0;
`endif
        end else begin
            rdy_q <= 1'b0;
            if (accept) begin
                state_q <= ST_ACCESS;
                cnt_q   <= CNT_W'(WAIT_STATES);
                addr_q  <= bus.core_ad;
                rw_q    <= bus.core_rw;
                wdata_q <= bus.core_dout;
                ce_n_q  <= 1'b0;
                oe_n_q  <= !bus.core_rw;
                we_n_q  <= bus.core_rw;
`ifdef MEM_CTRL_PREFETCH_EN
                if (!bus.core_rw) pf_pend_q <= 1'b0;
            end else if (hit_go) begin
                state_q   <= ST_HIT;
                rdy_q     <= 1'b1;
                rdata_q   <= pf_data;
                pf_pend_q <= 1'b1;
                pf_addr_q <= bus.core_ad + ADDR_W'(1);
            end else if (pf_start) begin
                // Prefetch reuses the normal read timing but never reports to the core.
                state_q   <= ST_ACCESS;
                cnt_q     <= CNT_W'(WAIT_STATES);
                addr_q    <= pf_addr_q;
                rw_q      <= 1'b1;
                ce_n_q    <= 1'b0;
                oe_n_q    <= 1'b0;
                we_n_q    <= 1'b1;
                pf_act_q  <= 1'b1;
                pf_pend_q <= 1'b0;
`endif
            end else if (acc_done) begin
                ce_n_q <= 1'b1;
                oe_n_q <= 1'b1;
                we_n_q <= 1'b1;
`ifdef MEM_CTRL_PREFETCH_EN
                if (pf_act_q) begin
                    state_q  <= ST_IDLE;
                    pf_act_q <= 1'b0;
                end else
`endif
                begin
                    state_q <= ST_DONE;
                    rdy_q   <= 1'b1;
                    if (rw_q) rdata_q <= bus.mem_dq_i;
`ifdef MEM_CTRL_PREFETCH_EN
                    if (rw_q) begin
                        pf_pend_q <= 1'b1;
                        pf_addr_q <= addr_q + ADDR_W'(1);
                    end
`endif
                end
            end else if (state_q == ST_ACCESS) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end else begin
                state_q <= ST_IDLE;
            end
        end
    end

    assign bus.core_din = rdata_q;
    assign bus.core_rdy = rdy_q;
    assign bus.mem_ce_n = ce_n_q;
    assign bus.mem_oe_n = oe_n_q;
    assign bus.mem_we_n = we_n_q;
    assign bus.mem_a    = addr_q;
    assign bus.mem_dq_o = wdata_q;
endmodule

// File: tb/tb_mem_ctrl.sv
// Directed testbench for mem_ctrl: WAIT_STATES=1 instance with an SRAM model,
// plus a WAIT_STATES=0 instance for the zero-wait boundary.
module tb_mem_ctrl;
    import mem_ctrl_pkg::*;

    localparam int WS = 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    logic [7:0] sram [0:65535];

    always #5 clk = ~clk;

    mem_ctrl_if bus ();
    mem_ctrl_if bus0 ();

    mem_ctrl #(.WAIT_STATES(WS)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
    mem_ctrl #(.WAIT_STATES(0))  dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));

    assign bus.mem_dq_i  = sram[bus.mem_a];
    assign bus0.mem_dq_i = 8'h3C;

    always @(posedge clk)
        if (!bus.mem_ce_n && !bus.mem_we_n) sram[bus.mem_a] = bus.mem_dq_o;

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (bus.mem_ce_n !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Issues one transfer and measures latency (cycles after acceptance) and strobe activity.
    task automatic run_xfer(input logic rw, input logic [15:0] ad, input logic [7:0] dout,
                            output int lat, output int oe_c, output int we_c, output logic a_ok);
        wait_idle();
        bus.core_req  = 1'b1;
        bus.core_rw   = rw;
        bus.core_ad   = ad;
        bus.core_dout = dout;
        lat = 0; oe_c = 0; we_c = 0; a_ok = 1'b1;
        do begin
            @(negedge clk);
            lat++;
            if (bus.mem_oe_n === 1'b0) begin
                oe_c++;
                if (bus.mem_a !== ad) a_ok = 1'b0;
            end
            if (bus.mem_we_n === 1'b0) begin
                we_c++;
                if (bus.mem_a !== ad || bus.mem_dq_o !== dout) a_ok = 1'b0;
            end
        end while (bus.core_rdy !== 1'b1 && lat < 40);
        bus.core_req = 1'b0;
    endtask

    task automatic test_reset();
        bus.core_req = 1'b0; bus.core_rw = 1'b1; bus.core_ad = 16'h0; bus.core_dout = 8'h0;
        bus0.core_req = 1'b0; bus0.core_rw = 1'b1; bus0.core_ad = 16'h0; bus0.core_dout = 8'h0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.core_rdy !== 1'b0) begin failures++; $display("FAIL reset_rdy got=%b exp=0", bus.core_rdy); end
        checks++;
        if (bus.core_din !== 8'h00) begin failures++; $display("FAIL reset_din got=%h exp=00", bus.core_din); end
        checks++;
        if ({bus.mem_ce_n, bus.mem_oe_n, bus.mem_we_n} !== 3'b111) begin
            failures++; $display("FAIL reset_strobes got=%b exp=111", {bus.mem_ce_n, bus.mem_oe_n, bus.mem_we_n});
        end
        checks++;
        if (bus.mem_a !== 16'h0000) begin failures++; $display("FAIL reset_mem_a got=%h exp=0000", bus.mem_a); end
        checks++;
        if (bus.mem_dq_o !== 8'h00) begin failures++; $display("FAIL reset_dq_o got=%h exp=00", bus.mem_dq_o); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.core_rdy !== 1'b0 || bus.mem_ce_n !== 1'b1) begin
            failures++; $display("FAIL post_reset_idle rdy=%b ce_n=%b exp rdy=0 ce_n=1", bus.core_rdy, bus.mem_ce_n);
        end
    endtask

    task automatic test_read();
        int lat, oe_c, we_c;
        logic a_ok;
        sram[16'h1234] = 8'hA9;
        run_xfer(1'b1, 16'h1234, 8'h00, lat, oe_c, we_c, a_ok);
        checks++;
        if (lat !== WS + 2) begin failures++; $display("FAIL read_latency got=%0d exp=%0d", lat, WS + 2); end
        checks++;
        if (bus.core_din !== 8'hA9) begin failures++; $display("FAIL read_din got=%h exp=a9", bus.core_din); end
        checks++;
        if (oe_c !== WS + 1) begin failures++; $display("FAIL read_oe_cycles got=%0d exp=%0d", oe_c, WS + 1); end
        checks++;
        if (we_c !== 0) begin failures++; $display("FAIL read_we_cycles got=%0d exp=0", we_c); end
        checks++;
        if (a_ok !== 1'b1) begin failures++; $display("FAIL read_mem_a got=bad exp=1234"); end
        @(negedge clk);
        checks++;
        if (bus.core_rdy !== 1'b0) begin failures++; $display("FAIL read_rdy_pulse got=%b exp=0", bus.core_rdy); end
        checks++;
        if ({bus.mem_ce_n, bus.mem_oe_n, bus.mem_we_n} !== 3'b111) begin
            failures++; $display("FAIL read_strobes_after got=%b exp=111", {bus.mem_ce_n, bus.mem_oe_n, bus.mem_we_n});
        end
    endtask

    task automatic test_write();
        int lat, oe_c, we_c;
        logic a_ok;
        sram[16'h0200] = 8'h00;
        run_xfer(1'b0, 16'h0200, 8'h5A, lat, oe_c, we_c, a_ok);
        checks++;
        if (lat !== WS + 2) begin failures++; $display("FAIL write_latency got=%0d exp=%0d", lat, WS + 2); end
        checks++;
        if (we_c !== WS + 1) begin failures++; $display("FAIL write_we_cycles got=%0d exp=%0d", we_c, WS + 1); end
        checks++;
        if (oe_c !== 0) begin failures++; $display("FAIL write_oe_cycles got=%0d exp=0", oe_c); end
        checks++;
        if (a_ok !== 1'b1) begin failures++; $display("FAIL write_addr_data got=bad exp=0200/5a"); end
        checks++;
        if (sram[16'h0200] !== 8'h5A) begin failures++; $display("FAIL write_sram got=%h exp=5a", sram[16'h0200]); end
        checks++;
        if (bus.core_din !== 8'hA9) begin failures++; $display("FAIL write_din_hold got=%h exp=a9", bus.core_din); end
        @(negedge clk);
        checks++;
        if (bus.core_rdy !== 1'b0) begin failures++; $display("FAIL write_rdy_pulse got=%b exp=0", bus.core_rdy); end
    endtask

    task automatic test_back_to_back();
        int n = 0, got = 0, t1 = 0, t2 = 0;
        logic gap = 1'b0;
        logic [7:0] d1 = 8'h00, d2 = 8'h00;
        sram[16'h0000] = 8'h11;
        sram[16'h0001] = 8'h22;
        wait_idle();
        bus.core_req = 1'b1; bus.core_rw = 1'b1; bus.core_ad = 16'h0000;
        while (got < 2 && n < 40) begin
            @(negedge clk);
            n++;
            if (bus.core_rdy === 1'b1) begin
                got++;
                if (got == 1) begin
                    d1 = bus.core_din; t1 = n; bus.core_ad = 16'h0001;
                end else begin
                    d2 = bus.core_din; t2 = n; bus.core_req = 1'b0;
                end
            end else if (got == 1 && bus.mem_ce_n !== 1'b0) begin
                gap = 1'b1;
            end
        end
        bus.core_req = 1'b0;
        checks++;
        if (t1 !== WS + 2) begin failures++; $display("FAIL b2b_first_rdy got=%0d exp=%0d", t1, WS + 2); end
        checks++;
        if (t2 !== 2 * (WS + 2)) begin failures++; $display("FAIL b2b_second_rdy got=%0d exp=%0d", t2, 2 * (WS + 2)); end
        checks++;
        if (d1 !== 8'h11) begin failures++; $display("FAIL b2b_first_din got=%h exp=11", d1); end
        checks++;
        if (d2 !== 8'h22) begin failures++; $display("FAIL b2b_second_din got=%h exp=22", d2); end
        checks++;
        if (gap !== 1'b0) begin failures++; $display("FAIL b2b_idle_gap got=1 exp=0"); end
    endtask

    task automatic test_reset_abort();
        int lat, oe_c, we_c;
        logic a_ok;
        logic seen = 1'b0;
        wait_idle();
        bus.core_req = 1'b1; bus.core_rw = 1'b1; bus.core_ad = 16'h1234;
        @(negedge clk);
        checks++;
        if ({bus.mem_ce_n, bus.mem_oe_n, bus.mem_we_n} !== 3'b001) begin
            failures++; $display("FAIL abort_in_access got=%b exp=001", {bus.mem_ce_n, bus.mem_oe_n, bus.mem_we_n});
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.mem_ce_n, bus.mem_oe_n, bus.mem_we_n} !== 3'b111) begin
            failures++; $display("FAIL abort_async_strobes got=%b exp=111", {bus.mem_ce_n, bus.mem_oe_n, bus.mem_we_n});
        end
        checks++;
        if (bus.core_din !== 8'h00 || bus.mem_a !== 16'h0000) begin
            failures++; $display("FAIL abort_reset_values din=%h mem_a=%h exp 00/0000", bus.core_din, bus.mem_a);
        end
        bus.core_req = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (bus.core_rdy !== 1'b0) seen = 1'b1;
        end
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (bus.core_rdy !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin failures++; $display("FAIL abort_no_rdy got=1 exp=0"); end
        run_xfer(1'b1, 16'h1234, 8'h00, lat, oe_c, we_c, a_ok);
        checks++;
        if (lat !== WS + 2) begin failures++; $display("FAIL abort_next_latency got=%0d exp=%0d", lat, WS + 2); end
        checks++;
        if (bus.core_din !== 8'hA9) begin failures++; $display("FAIL abort_next_din got=%h exp=a9", bus.core_din); end
    endtask

    task automatic test_ws0();
        int lat = 0, oe_c = 0;
        @(negedge clk);
        bus0.core_req = 1'b1; bus0.core_rw = 1'b1; bus0.core_ad = 16'h0042;
        do begin
            @(negedge clk);
            lat++;
            if (bus0.mem_oe_n === 1'b0) oe_c++;
        end while (bus0.core_rdy !== 1'b1 && lat < 40);
        bus0.core_req = 1'b0;
        checks++;
        if (lat !== 2) begin failures++; $display("FAIL ws0_latency got=%0d exp=2", lat); end
        checks++;
        if (oe_c !== 1) begin failures++; $display("FAIL ws0_oe_cycles got=%0d exp=1", oe_c); end
        checks++;
        if (bus0.core_din !== 8'h3C) begin failures++; $display("FAIL ws0_din got=%h exp=3c", bus0.core_din); end
    endtask

`ifdef MEM_CTRL_PREFETCH_EN
    task automatic test_prefetch();
        int lat, oe_c, we_c;
        logic a_ok;
        sram[16'hFFFF] = 8'h77;
        sram[16'h0000] = 8'h11;
        run_xfer(1'b1, 16'hFFFF, 8'h00, lat, oe_c, we_c, a_ok);
        checks++;
        if (lat !== WS + 2 || bus.core_din !== 8'h77) begin
            failures++; $display("FAIL pf_first_read lat=%0d din=%h exp %0d/77", lat, bus.core_din, WS + 2);
        end
        repeat (6) @(negedge clk);
        run_xfer(1'b1, 16'h0000, 8'h00, lat, oe_c, we_c, a_ok);
        checks++;
        if (lat !== 1) begin failures++; $display("FAIL pf_hit_latency got=%0d exp=1", lat); end
        checks++;
        if (bus.core_din !== 8'h11) begin failures++; $display("FAIL pf_hit_din got=%h exp=11", bus.core_din); end
        run_xfer(1'b0, 16'h0000, 8'h99, lat, oe_c, we_c, a_ok);
        run_xfer(1'b1, 16'h0000, 8'h00, lat, oe_c, we_c, a_ok);
        checks++;
        if (lat !== WS + 2) begin failures++; $display("FAIL pf_miss_after_write got=%0d exp=%0d", lat, WS + 2); end
        checks++;
        if (bus.core_din !== 8'h99) begin failures++; $display("FAIL pf_miss_din got=%h exp=99", bus.core_din); end
    endtask
`endif

    initial begin
        test_reset();
        test_read();
        test_write();
        test_back_to_back();
        test_reset_abort();
        test_ws0();
`ifdef MEM_CTRL_PREFETCH_EN
        test_prefetch();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 Parameter WAIT_STATES, default 1: extra memory-access cycles per transfer, legal range 0..15.
REQ-002 clk  input  1  single clock; all state changes on posedge clk.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 core_req  input  1  core presents a valid transfer this cycle.
REQ-005 core_rw  input  1  1=read, 0=write, same polarity as the core RW output.
REQ-006 core_ad  input  16  core byte address.
REQ-007 core_dout  input  8  core write data.
REQ-008 core_din  output  8  read data returned to the core.
REQ-009 core_rdy  output  1  one-cycle pulse: read data valid or write complete.
REQ-010 mem_ce_n, mem_oe_n, mem_we_n  output  1 each  external SRAM strobes, active-low.
REQ-011 mem_a  output  16  SRAM address.
REQ-012 mem_dq_o  output  8  SRAM write data.
REQ-013 mem_dq_i  input  8  SRAM read data.

Function
REQ-014 The state machine SHALL have states IDLE, ACCESS, DONE, plus HIT when prefetch is compiled in.
REQ-015 In IDLE with core_req=1, the block SHALL latch core_ad, core_rw and core_dout, load the wait counter with WAIT_STATES, and enter ACCESS.
REQ-016 In ACCESS: mem_ce_n=0, mem_a=latched address, mem_oe_n=!rw, mem_we_n=rw, mem_dq_o=latched data; the counter decrements each cycle.
REQ-017 In ACCESS with counter==0, the block SHALL capture mem_dq_i into the read register (reads only) and enter DONE.
REQ-018 In DONE, core_rdy SHALL be 1 and core_din SHALL equal the captured byte; all mem strobes are deasserted.
REQ-019 Latency from request acceptance to core_rdy SHALL be exactly WAIT_STATES+2 cycles.
REQ-020 In DONE with core_req=1, the block SHALL accept the next request immediately (go to ACCESS); otherwise it returns to IDLE.
REQ-021 The core SHALL hold core_req and its request fields stable until core_rdy; the block ignores changes to them outside IDLE/DONE.
REQ-022 core_din SHALL hold its last captured value until the next read completes.
REQ-023 Outside ACCESS (and outside any prefetch access), mem_ce_n, mem_oe_n and mem_we_n SHALL all be 1.

Reset
REQ-024 While rst_n=0, the block SHALL be in IDLE with core_rdy=0, core_din=8'h00, all mem strobes 1, mem_a=16'h0000, mem_dq_o=8'h00, counter=0 and prefetch valid=0.
REQ-025 Assertion of rst_n in ACCESS SHALL abort the transfer immediately; no core_rdy pulse follows.

Configuration
REQ-026 With macro MEM_CTRL_PREFETCH_EN defined, the block SHALL include a one-byte sequential prefetch buffer; without it, REQ-027..REQ-031 are absent and behaviour is exactly REQ-014..REQ-025.
REQ-027 After a read of address N completes, and only when IDLE with core_req=0, the block SHALL read N+1 (mod 2^16, so 16'hFFFF prefetches 16'h0000) into the buffer using the ACCESS timing, then set valid.
REQ-028 A read request in IDLE or DONE whose address equals a valid buffer address SHALL enter HIT, return the buffered byte with core_rdy one cycle later (latency 1), and trigger a prefetch of the next address.
REQ-029 A request arriving during a prefetch access SHALL wait until the prefetch completes, then be evaluated for hit or miss.
REQ-030 Any accepted write SHALL clear the valid flag.
REQ-031 A prefetch never raises core_rdy.

Structure
REQ-032 Package mem_ctrl_pkg SHALL hold the state enum, ADDR_W=16, DATA_W=8 and the counter width (4).
REQ-033 The prefetch register, address tag, valid flag and comparator SHALL live in a sub-module mem_ctrl_prefetch, instantiated only under MEM_CTRL_PREFETCH_EN.

Verification
REQ-034 WAIT_STATES=1, read 16'h1234 with mem_dq_i=8'hA9 -> core_rdy pulses 3 cycles after acceptance, core_din=8'hA9, mem_oe_n low 2 cycles.
REQ-035 Write 8'h5A to 16'h0200 -> mem_we_n low WAIT_STATES+1 cycles with mem_a=16'h0200 and mem_dq_o=8'h5A; core_rdy pulses once; mem_oe_n stays 1.
REQ-036 Back-to-back reads of 16'h0000 and 16'h0001 with core_req held high -> second access starts in the DONE cycle of the first, with no IDLE cycle between.
REQ-037 rst_n pulled low in ACCESS -> strobes go to 1 asynchronously, no core_rdy pulse; the next request after release completes normally.
REQ-038 MEM_CTRL_PREFETCH_EN: read 16'hFFFF, idle, then read 16'h0000 -> hit with core_rdy 1 cycle after request; an intervening write to 16'h0000 -> miss with full latency.
